// File: rtl/debug_view_controller_pkg.sv
// Shared types for the debug-view controller: CPU state bus, buttons, colour LEDs,
// view modes and the slide-switch bit assignments.
package debug_view_controller_pkg;

    localparam int CPU_NUM_REGS = 8;
    localparam int CPU_IDX_W    = $clog2(CPU_NUM_REGS);

    typedef struct packed {
        logic [CPU_NUM_REGS-1:0][31:0] registers;
        logic [31:0]                   pc;
        logic [31:0]                   cmd;
        logic [2:0]                    memory_state;
    } internal_state_bus_t;

    typedef struct packed {
        logic center;
        logic up;
        logic down;
        logic left;
        logic right;
    } buttons_t;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } color_t;

    typedef enum logic [1:0] {
        VIEW_REG = 2'd0,
        VIEW_PC  = 2'd1,
        VIEW_CMD = 2'd2
    } view_mode_t;

    localparam int SW_FREEZE     = 15;
    localparam int SW_LED_IDX    = 14;
    localparam int SW_AUTOSCROLL = 0;

    function automatic view_mode_t view_next(input view_mode_t v);
        case (v)
            VIEW_REG: return VIEW_PC;
            VIEW_PC:  return VIEW_CMD;
            default:  return VIEW_REG;
        endcase
    endfunction

    function automatic view_mode_t view_prev(input view_mode_t v);
        case (v)
            VIEW_REG: return VIEW_CMD;
            VIEW_PC:  return VIEW_REG;
            default:  return VIEW_PC;
        endcase
    endfunction

endpackage

// File: rtl/debug_view_controller_button_debouncer.sv
// Two-flop synchroniser plus counting debouncer for one push-button; emits a
// one-cycle press pulse on each debounced 0->1 transition.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock_100mhz,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             raw_meta;
    logic             synced;
    logic             stable_q;
    logic [CNT_W-1:0] count;

    // NOTE: every register here is written with <= so all flops sample the
    // pre-edge values together, which is what makes the synchroniser a chain.
    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            raw_meta <= 1'b0;
            synced   <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            press    <= 1'b0;
            count    <= '0;
        end else begin
            raw_meta <= raw;
            synced   <= raw_meta;
            stable_q <= stable;
            press    <= stable & ~stable_q;
            if (synced == stable) begin
                count <= '0;
            end else if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= synced;
                count  <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/debug_view_controller.sv
// Debug-view controller: button-driven register/pc/cmd viewer with freeze and LED status.
// Optional auto-scroll of the register index is enabled by defining DEBUG_VIEW_AUTOSCROLL_EN.
module debug_view_controller
    import debug_view_controller_pkg::*;
#(
    parameter int         NUM_REGS          = 5,
    parameter int         WORD_WIDTH        = 32,
    parameter int         DEBOUNCE_CYCLES   = 1_000_000,
    parameter int         AUTOSCROLL_CYCLES = 100_000_000,
    parameter logic [7:0] LED_LEVEL         = 8'h40,
    localparam int        IDX_W             = $clog2(NUM_REGS)
) (
    input  logic                  clock_100mhz,
    input  logic                  reset,
    input  internal_state_bus_t   cpu_state,
    input  buttons_t              buttons,
    input  logic [15:0]           switches,
    output logic [WORD_WIDTH-1:0] displayed_word,
    output logic [IDX_W-1:0]      displayed_idx,
    output logic                  flash_upper_half,
    output logic                  flash_lower_half,
    output logic [15:0]           mono_leds,
    output color_t                left_led,
    output color_t                right_led
);

    logic [4:0] raw_vec;
    logic [4:0] stable_vec;
    logic [4:0] press_vec;
    buttons_t   press;

    assign raw_vec = buttons;
    assign press   = press_vec;

    for (genvar i = 0; i < 5; i++) begin : g_debounce
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
            .clock_100mhz (clock_100mhz),
            .reset        (reset),
            .raw          (raw_vec[i]),
            .stable       (stable_vec[i]),
            .press        (press_vec[i])
        );
    end

    logic [1:0] sw_meta, sw_sync;
    logic       frozen, led_idx_mode;

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= {switches[SW_FREEZE], switches[SW_LED_IDX]};
            sw_sync <= sw_meta;
        end
    end

    assign frozen       = sw_sync[1];
    assign led_idx_mode = sw_sync[0];

    view_mode_t       view;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc, idx_dec;
    logic             scroll_tick;

    assign idx_inc = (idx == IDX_W'(NUM_REGS - 1)) ? '0 : idx + IDX_W'(1);
    assign idx_dec = (idx == '0) ? IDX_W'(NUM_REGS - 1) : idx - IDX_W'(1);

`ifdef DEBUG_VIEW_AUTOSCROLL_EN
    localparam int SCROLL_W = $clog2(AUTOSCROLL_CYCLES);

    logic                autoscroll_meta, autoscroll_sw, scroll_active;
    logic [SCROLL_W-1:0] scroll_timer;
    logic                unused_inputs;

    assign scroll_active = autoscroll_sw && (view == VIEW_REG) && !frozen;
    assign scroll_tick   = scroll_active && (scroll_timer == SCROLL_W'(AUTOSCROLL_CYCLES - 1));

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            autoscroll_meta <= 1'b0;
            autoscroll_sw   <= 1'b0;
            scroll_timer    <= '0;
        end else begin
            autoscroll_meta <= switches[SW_AUTOSCROLL];
            autoscroll_sw   <= autoscroll_meta;
            if (!scroll_active || (|press_vec) || scroll_tick)
                scroll_timer <= '0;
            else
                scroll_timer <= scroll_timer + SCROLL_W'(1);
        end
    end

    assign unused_inputs = ^{switches[SW_LED_IDX-1:SW_AUTOSCROLL+1], stable_vec};
`else
    localparam int unused_autoscroll_cycles = AUTOSCROLL_CYCLES;

    logic unused_inputs;

    assign scroll_tick   = 1'b0;
    assign unused_inputs = ^{switches[SW_LED_IDX-1:SW_AUTOSCROLL], stable_vec};
`endif

    // Only the highest-priority press acts; auto-scroll yields to any press.
    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            idx  <= '0;
            view <= VIEW_REG;
        end else if (press.center) begin
            idx  <= '0;
            view <= VIEW_REG;
        end else if (press.up) begin
            if (view == VIEW_REG) idx <= idx_inc;
        end else if (press.down) begin
            if (view == VIEW_REG) idx <= idx_dec;
        end else if (press.left) begin
            view <= view_prev(view);
        end else if (press.right) begin
            view <= view_next(view);
        end else if (scroll_tick) begin
            idx <= idx_inc;
        end
    end

    assign displayed_idx = idx;

    logic [WORD_WIDTH-1:0] selected_word;
    logic [15:0]           idx_onehot;

    // NOTE: each always_comb output gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        selected_word = '0;
        case (view)
            VIEW_PC:  selected_word = WORD_WIDTH'(cpu_state.pc);
            VIEW_CMD: selected_word = WORD_WIDTH'(cpu_state.cmd);
            default:  selected_word = WORD_WIDTH'(cpu_state.registers[CPU_IDX_W'(idx)]);
        endcase
    end

    assign idx_onehot = 16'(1) << idx;

    function automatic color_t cmd_colour(input logic [3:0] op);
        color_t c;
        c = '0;
        case (op)
            4'd0:    c.red   = LED_LEVEL;
            4'd1:    c.green = LED_LEVEL;
            4'd2:    c.blue  = LED_LEVEL;
            default: c       = '0;
        endcase
        return c;
    endfunction

    function automatic color_t mem_colour(input logic [2:0] state);
        color_t c;
        c = '0;
        case (state)
            3'd3:       c.red   = LED_LEVEL;
            3'd1, 3'd2: c.green = LED_LEVEL;
            3'd4, 3'd5: c.blue  = LED_LEVEL;
            default:    c       = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            displayed_word   <= '0;
            flash_upper_half <= 1'b0;
            flash_lower_half <= 1'b0;
            mono_leds        <= '0;
            left_led         <= '0;
            right_led        <= '0;
        end else begin
            if (!frozen) displayed_word <= selected_word;
            flash_upper_half <= frozen;
            flash_lower_half <= frozen;
            mono_leds        <= led_idx_mode ? idx_onehot : cpu_state.pc[15:0];
            left_led         <= cmd_colour(cpu_state.cmd[31:28]);
            right_led        <= mem_colour(cpu_state.memory_state);
        end
    end

endmodule

// File: tb/tb_debug_view_controller.sv
// Directed bench for debug_view_controller with DEBOUNCE_CYCLES=4, NUM_REGS=5,
// AUTOSCROLL_CYCLES=16; expected values are hand-computed constants.
module tb_debug_view_controller;
    import debug_view_controller_pkg::*;

    logic                clock_100mhz = 1'b0;
    logic                reset;
    internal_state_bus_t cpu_state;
    buttons_t            buttons;
    logic [15:0]         switches;
    logic [31:0]         displayed_word;
    logic [2:0]          displayed_idx;
    logic                flash_upper_half, flash_lower_half;
    logic [15:0]         mono_leds;
    color_t              left_led, right_led;

    int vectors     = 0;
    int miscompares = 0;

    localparam buttons_t B_NONE   = '0;
    localparam buttons_t B_CENTER = 5'b10000;
    localparam buttons_t B_UP     = 5'b01000;
    localparam buttons_t B_DOWN   = 5'b00100;
    localparam buttons_t B_LEFT   = 5'b00010;
    localparam buttons_t B_RIGHT  = 5'b00001;

    localparam color_t C_OFF   = '0;
    localparam color_t C_RED   = {8'h40, 8'h00, 8'h00};
    localparam color_t C_GREEN = {8'h00, 8'h40, 8'h00};
    localparam color_t C_BLUE  = {8'h00, 8'h00, 8'h40};

    debug_view_controller #(
        .NUM_REGS          (5),
        .WORD_WIDTH        (32),
        .DEBOUNCE_CYCLES   (4),
        .AUTOSCROLL_CYCLES (16),
        .LED_LEVEL         (8'h40)
    ) dut (
        .clock_100mhz     (clock_100mhz),
        .reset            (reset),
        .cpu_state        (cpu_state),
        .buttons          (buttons),
        .switches         (switches),
        .displayed_word   (displayed_word),
        .displayed_idx    (displayed_idx),
        .flash_upper_half (flash_upper_half),
        .flash_lower_half (flash_lower_half),
        .mono_leds        (mono_leds),
        .left_led         (left_led),
        .right_led        (right_led)
    );

    always #5 clock_100mhz = ~clock_100mhz;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock_100mhz);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Hold long enough for the press to act and the word to follow, then release and settle.
    task automatic press_btn(input buttons_t b);
        buttons = b;
        ticks(9);
        buttons = B_NONE;
        ticks(8);
    endtask

    task automatic wait_idx_change(output int n);
        logic [2:0] start_idx;
        start_idx = displayed_idx;
        n = 0;
        while (displayed_idx === start_idx && n < 64) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        buttons  = B_NONE;
        switches = '0;
        cpu_state = '0;
        for (int k = 0; k < CPU_NUM_REGS; k++)
            cpu_state.registers[k] = 32'h1000_0000 + 32'(k);
        cpu_state.pc           = 32'h0000_BEEF;
        cpu_state.cmd          = 32'h3000_0000;
        cpu_state.memory_state = 3'd0;
        ticks(3);

        check("reset_idx", 64'(displayed_idx), 64'd0);
        check("reset_word", 64'(displayed_word), 64'd0);
        check("reset_mono", 64'(mono_leds), 64'd0);
        check("reset_flash", 64'({flash_upper_half, flash_lower_half}), 64'd0);

        reset = 1'b0;
        ticks(2);
        check("post_reset_word", 64'(displayed_word), 64'h1000_0000);
        check("post_reset_mono", 64'(mono_leds), 64'hBEEF);
        check("post_reset_leds", 64'({left_led, right_led}), 64'd0);

        // Held up: press acts at edge 7 after first sample, word follows at edge 8.
        buttons = B_UP;
        ticks(7);
        check("up_idx_edge6", 64'(displayed_idx), 64'd0);
        tick();
        check("up_idx_edge7", 64'(displayed_idx), 64'd1);
        check("up_word_edge7", 64'(displayed_word), 64'h1000_0000);
        tick();
        check("up_word_edge8", 64'(displayed_word), 64'h1000_0001);
        ticks(21);
        check("up_held_single", 64'(displayed_idx), 64'd1);
        buttons = B_NONE;
        ticks(8);

        buttons = B_UP;
        ticks(2);
        buttons = B_NONE;
        ticks(10);
        check("glitch_ignored", 64'(displayed_idx), 64'd1);

        press_btn(B_CENTER);
        check("center_idx", 64'(displayed_idx), 64'd0);
        press_btn(B_DOWN);
        check("down_wrap_idx", 64'(displayed_idx), 64'd4);
        check("down_wrap_word", 64'(displayed_word), 64'h1000_0004);
        press_btn(B_UP);
        check("up_wrap_idx", 64'(displayed_idx), 64'd0);

        press_btn(B_UP);
        check("up_idx1", 64'(displayed_idx), 64'd1);
        press_btn(B_RIGHT);
        check("view_pc_word", 64'(displayed_word), 64'h0000_BEEF);
        press_btn(B_UP);
        check("up_in_pc_view", 64'(displayed_idx), 64'd1);
        press_btn(B_RIGHT);
        check("view_cmd_word", 64'(displayed_word), 64'h3000_0000);
        press_btn(B_RIGHT);
        check("view_reg_word", 64'(displayed_word), 64'h1000_0001);
        press_btn(B_LEFT);
        check("left_to_cmd", 64'(displayed_word), 64'h3000_0000);
        press_btn(B_LEFT);
        check("left_to_pc", 64'(displayed_word), 64'h0000_BEEF);
        press_btn(B_LEFT);
        check("left_to_reg", 64'(displayed_word), 64'h1000_0001);
        press_btn(B_CENTER | B_UP);
        check("center_beats_up", 64'(displayed_idx), 64'd0);
        check("center_word", 64'(displayed_word), 64'h1000_0000);

        switches[SW_FREEZE] = 1'b1;
        ticks(4);
        check("freeze_flash", 64'({flash_upper_half, flash_lower_half}), 64'h3);
        cpu_state.registers[0] = 32'hDEAD_0000;
        cpu_state.registers[1] = 32'hCAFE_0001;
        ticks(3);
        check("frozen_word", 64'(displayed_word), 64'h1000_0000);
        press_btn(B_UP);
        check("frozen_idx_moves", 64'(displayed_idx), 64'd1);
        check("frozen_word_held", 64'(displayed_word), 64'h1000_0000);
        switches[SW_FREEZE] = 1'b0;
        ticks(4);
        check("unfreeze_word", 64'(displayed_word), 64'hCAFE_0001);
        check("unfreeze_flash", 64'({flash_upper_half, flash_lower_half}), 64'h0);

        press_btn(B_UP);
        press_btn(B_UP);
        switches[SW_LED_IDX] = 1'b1;
        ticks(4);
        check("mono_onehot_idx3", 64'(mono_leds), 64'h0008);
        switches[SW_LED_IDX] = 1'b0;
        ticks(4);
        check("mono_pc_again", 64'(mono_leds), 64'hBEEF);
        cpu_state.pc = 32'h0000_1234;
        tick();
        check("mono_pc_latency", 64'(mono_leds), 64'h1234);

        cpu_state.cmd = 32'h1000_0000;
        tick();
        check("left_green", 64'(left_led), 64'(C_GREEN));
        cpu_state.cmd = 32'h0ABC_0000;
        tick();
        check("left_red", 64'(left_led), 64'(C_RED));
        cpu_state.cmd = 32'h2000_0000;
        tick();
        check("left_blue", 64'(left_led), 64'(C_BLUE));
        cpu_state.cmd = 32'hF000_0000;
        tick();
        check("left_off", 64'(left_led), 64'(C_OFF));
        cpu_state.memory_state = 3'd5;
        tick();
        check("right_blue", 64'(right_led), 64'(C_BLUE));
        cpu_state.memory_state = 3'd3;
        tick();
        check("right_red", 64'(right_led), 64'(C_RED));
        cpu_state.memory_state = 3'd2;
        tick();
        check("right_green", 64'(right_led), 64'(C_GREEN));
        cpu_state.memory_state = 3'd7;
        tick();
        check("right_off", 64'(right_led), 64'(C_OFF));

        cpu_state.cmd          = 32'h1000_0000;
        cpu_state.memory_state = 3'd3;
        tick();
        reset = 1'b1;
        tick();
        check("midop_reset_idx", 64'(displayed_idx), 64'd0);
        check("midop_reset_word", 64'(displayed_word), 64'd0);
        check("midop_reset_leds", 64'({left_led, right_led}), 64'd0);
        reset = 1'b0;
        ticks(2);

        switches[SW_AUTOSCROLL] = 1'b1;
`ifdef DEBUG_VIEW_AUTOSCROLL_EN
        wait_idx_change(n);
        check("scroll_first_idx", 64'(displayed_idx), 64'd1);
        for (int s = 2; s <= 5; s++) begin
            wait_idx_change(n);
            check("scroll_period", 64'(n), 64'd16);
            check("scroll_idx", 64'(displayed_idx), 64'(s % 5));
        end
        ticks(5);
        buttons = B_UP;
        wait_idx_change(n);
        check("scroll_press_idx", 64'(displayed_idx), 64'd1);
        wait_idx_change(n);
        check("scroll_restart_period", 64'(n), 64'd16);
        check("scroll_restart_idx", 64'(displayed_idx), 64'd2);
        buttons = B_NONE;
`else
        ticks(40);
        check("autoscroll_ignored", 64'(displayed_idx), 64'd0);
`endif
        switches[SW_AUTOSCROLL] = 1'b0;
        ticks(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/debug_view_controller.md
# debug_view_controller

Parametrised debug-view controller between the CPU internal-state bus and the board's display peripherals. It debounces the five push-buttons, keeps a view mode and a register index, and produces a registered display word, flash flags, mono-LED pattern and two `color_t` LED colours. The top level feeds these to `dword_display` and `colour_led`. It generalises the fixed five-register button selector to N registers with wrap-around stepping, multiple view modes, a freeze/snapshot function, and optional auto-scroll.

## Interface
Parameters:
- `NUM_REGS`, 5: number of selectable registers (≥2); `IDX_W = $clog2(NUM_REGS)`.
- `WORD_WIDTH`, 32: width of the displayed word.
- `DEBOUNCE_CYCLES`, 1_000_000: cycles a synchronised button must differ from its stable value before the stable value updates (≥2).
- `AUTOSCROLL_CYCLES`, 100_000_000: auto-scroll period in cycles.
- `LED_LEVEL`, 8'h40: channel intensity for lit colour-LED channels.

Ports:
- `clock_100mhz`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_state`  in  `internal_state_bus_t`  CPU registers, pc, cmd, memory_state.
- `buttons`  in  `buttons_t`  raw, unsynchronised push-buttons.
- `switches`  in  16  raw slide switches. Bit 15 = freeze, bit 14 = LED index mode, bit 0 = auto-scroll.
- `displayed_word`  out  WORD_WIDTH  word for the seven-segment display.
- `displayed_idx`  out  IDX_W  current register index.
- `flash_upper_half`, `flash_lower_half`  out  1 each  display flash requests.
- `mono_leds`  out  16  mono LED pattern.
- `left_led`, `right_led`  out  `color_t`  colour-LED targets.

## Operation
- Each button passes through a 2-flop synchroniser, then a debouncer:
  - The counter increments while the synced value ≠ stable, and clears when they are equal.
  - At count `DEBOUNCE_CYCLES-1`, stable takes the synced value and the counter clears.
  - A one-cycle `press` pulse fires on a stable 0→1 transition.
- Same-cycle press priority: center > up > down > left > right. Only the highest-priority press acts.
- State:
  - `view` (`VIEW_REG`, `VIEW_PC`, `VIEW_CMD`).
  - `idx` (0..NUM_REGS-1).
- Actions:
  - center: idx←0, view←VIEW_REG.
  - up: idx←idx+1, wrapping NUM_REGS-1→0. Acts in VIEW_REG only.
  - down: idx←idx−1, wrapping 0→NUM_REGS-1. Acts in VIEW_REG only.
  - right: view advances REG→PC→CMD→REG.
  - left: view moves in reverse.
- `displayed_word` (registered):
  - VIEW_REG: `registers[idx]`.
  - VIEW_PC: `pc`, zero-extended or truncated to WORD_WIDTH.
  - VIEW_CMD: `cmd`.
- Freeze (`switches[15]`, synchronised):
  - While high, `displayed_word` holds its value; both flash flags are 1; buttons still update idx/view.
  - On release, `displayed_word` reloads from the current selection.
- `mono_leds`: `pc[15:0]` by default. With synced `switches[14]`=1, a one-hot of idx (bit idx set; bits ≥ NUM_REGS always 0).
- `left_led` (registered), from `cmd[31:28]`:
  - 0 → red=LED_LEVEL.
  - 1 → green=LED_LEVEL.
  - 2 → blue=LED_LEVEL.
  - Otherwise all 0.
- `right_led` (registered), from `memory_state`:
  - 3 → red.
  - 1 or 2 → green.
  - 4 or 5 → blue.
  - Otherwise all 0.
  - Lit channels use LED_LEVEL; the others are 0.
- Reset values:
  - idx=0, view=VIEW_REG.
  - `displayed_word`=0, flash flags=0, `mono_leds`=0, LEDs all 0.
  - Debouncer stable=0, counters=0; autoscroll timer=0.

## Timing
- Raw button rising edge held stable → press pulse `DEBOUNCE_CYCLES+2` cycles later (2 sync + debounce). idx/view update 1 cycle later; `displayed_word` 1 cycle after that. Total `DEBOUNCE_CYCLES+4`.
- A glitch shorter than `DEBOUNCE_CYCLES` synced cycles produces no press.
- A held button produces exactly one press. Release followed by a re-press produces another.
- CPU-state changes reach `displayed_word`, `mono_leds` and the LEDs with 1-cycle latency.
- Switch changes pass through a 2-flop synchroniser, then affect outputs 1 cycle later.
- A button held through reset deassertion is seen as a new press once debounced.

## Configuration
- `DEBUG_VIEW_AUTOSCROLL_EN` defined, with synced `switches[0]`=1, view=VIEW_REG and not frozen:
  - The timer counts to `AUTOSCROLL_CYCLES-1`, then idx increments with wrap and the timer clears.
  - Any press, or leaving these conditions, clears the timer.
- Undefined: the timer logic is absent, `switches[0]` is ignored, and `AUTOSCROLL_CYCLES` is unused.

## Structure
- The `peripherals` package gains:
  - `view_mode_t` enum: VIEW_REG=0, VIEW_PC=1, VIEW_CMD=2.
  - Switch bit-position constants `SW_FREEZE=15`, `SW_LED_IDX=14`, `SW_AUTOSCROLL=0`.
- Sub-module `button_debouncer`: parameter `DEBOUNCE_CYCLES`; ports `clock_100mhz`, `reset`, `raw`, `stable`, `press`. It is instantiated five times.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, NUM_REGS=5, AUTOSCROLL_CYCLES=16.
- Reset asserted mid-operation → next cycle idx=0, view=VIEW_REG, `displayed_word`=0, LEDs=0.
- Registers[k]=32'h1000_000k; hold up from reset for 30 cycles → idx=1 at exactly cycle 7 after the first sampled high, `displayed_word`=32'h1000_0001 at cycle 8, no further steps. Pulse up for 2 cycles → no change.
- From idx=0 press down → idx=4. Press up → idx=0. With view=VIEW_PC, press up → idx unchanged.
- Press right twice → `displayed_word`=cmd. Press right again → registers[idx]. Press center and up in the same cycle → idx=0.
- pc=16'hBEEF, switches[15]=1, change registers → `displayed_word` frozen, flash flags=1. Release → new value. switches[14]=1, idx=3 → `mono_leds`=16'h0008.
- With `DEBUG_VIEW_AUTOSCROLL_EN` and switches[0]=1 → idx steps every 16 cycles (4→0 wrap). A press restarts the period. cmd[31:28]=1 → `left_led`={0,8'h40,0}. memory_state=5 → `right_led` blue=8'h40.
